seg_scan_display: RTL

Parametrised multiplexed seven-segment display controller for N common-anode digits. It converts a binary value to BCD with a sequential double-dabble engine and holds the result in a display register. It scans the digits at a programmable refresh rate, with leading-zero blanking, per-digit decimal points, overflow indication and optional per-digit blinking. It sits between game/score logic and the board's anode and segment pins.

---
 rtl/seg_scan_display.sv | 291 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// ----------------------------------------------------------------------------
// seg_scan_display
//
// Multiplexed seven-segment display controller for NUM_DIGITS common-anode
// digits. A binary value captured on `load` is converted to BCD by a
// sequential double-dabble engine (one bit per clock). The result lands in a
// display register that a free-running scanner walks through, one digit per
// REFRESH_DIV clocks, with leading-zero blanking, per-digit decimal points
// and an overflow dash pattern.
//
// Optional feature macro: DISP_BLINK_EN
//   Defined   -> a blink phase toggles every BLINK_TICKS scan ticks. While the
//                phase is 1, digits selected by blink_mask are blanked
//                (segments and dp off) with their anode still driven.
//   Undefined -> no blink logic is built and blink_mask is ignored.
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high reset
//   value       in   [VAL_W-1:0] binary number to display
//   load        in   one-cycle strobe, captures value when not busy
//   blank_lz    in   1 = blank leading zeros
//   dp_in       in   [NUM_DIGITS-1:0] decimal-point request, bit 0 = rightmost
//   blink_mask  in   [NUM_DIGITS-1:0] digits to blink (DISP_BLINK_EN only)
//   busy        out  conversion in progress
//   ovf         out  last completed conversion exceeded 10^NUM_DIGITS-1
//   an          out  [NUM_DIGITS-1:0] anode enables, active-low, one-cold
//   seg         out  [6:0] segments {g,f,e,d,c,b,a}, active-low
//   dp          out  decimal point, active-low
// ----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int VAL_W       = 14,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [VAL_W-1:0]      value,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic [NUM_DIGITS-1:0] dp_in,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  output logic                  busy,
  output logic                  ovf,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int BCD_W   = 4 * NUM_DIGITS;
  localparam int SEL_W   = $clog2(NUM_DIGITS);
  localparam int PRE_W   = $clog2(REFRESH_DIV);
  localparam int ITER_W  = $clog2(VAL_W);
  localparam int BLINK_W = $clog2(BLINK_TICKS + 1);

  localparam logic [6:0] SEG_OFF  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // --------------------------------------------------------------------------
  // Converter FSM
  // --------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [VAL_W-1:0]   bin_reg, bin_next;
  logic [BCD_W-1:0]   work_reg, work_next;
  logic [BCD_W-1:0]   disp_reg, disp_next;
  logic               work_ovf_reg, work_ovf_next;
  logic               ovf_reg, ovf_next;
  logic [ITER_W-1:0]  iter_reg, iter_next;

  // Working BCD after the "add 3 to every nibble >= 5" step.
  logic [BCD_W-1:0]   work_adj;
  // Result of one complete iteration (adjust, then shift in the next bin bit).
  logic [BCD_W-1:0]   work_shifted;
  logic               work_ovf_shifted;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adjust
      assign work_adj[4*gi +: 4] = (work_reg[4*gi +: 4] >= 4'd5)
                                   ? work_reg[4*gi +: 4] + 4'd3
                                   : work_reg[4*gi +: 4];
    end
  endgenerate

  assign work_shifted     = {work_adj[BCD_W-2:0], bin_reg[VAL_W-1]};
  // Any 1 leaving the top of the BCD field means the value has no
  // NUM_DIGITS-digit decimal representation; the flag is sticky.
  assign work_ovf_shifted = work_ovf_reg | work_adj[BCD_W-1];

  always_comb begin
    state_next    = state_reg;
    bin_next      = bin_reg;
    work_next     = work_reg;
    work_ovf_next = work_ovf_reg;
    iter_next     = iter_reg;
    disp_next     = disp_reg;
    ovf_next      = ovf_reg;

    case (state_reg)
      ST_IDLE: begin
        if (load) begin
          bin_next      = value;
          work_next     = '0;
          work_ovf_next = 1'b0;
          iter_next     = '0;
          state_next    = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_next      = {bin_reg[VAL_W-2:0], 1'b0};
        work_next     = work_shifted;
        work_ovf_next = work_ovf_shifted;
        iter_next     = iter_reg + 1'b1;
        // The final iteration writes straight into the display register so
        // busy is high for exactly VAL_W cycles and drops on the same edge
        // that the result becomes visible.
        if (iter_reg == ITER_W'(VAL_W - 1)) begin
          disp_next  = work_shifted;
          ovf_next   = work_ovf_shifted;
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      bin_reg      <= '0;
      work_reg     <= '0;
      work_ovf_reg <= 1'b0;
      iter_reg     <= '0;
      disp_reg     <= '0;
      ovf_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      bin_reg      <= bin_next;
      work_reg     <= work_next;
      work_ovf_reg <= work_ovf_next;
      iter_reg     <= iter_next;
      disp_reg     <= disp_next;
      ovf_reg      <= ovf_next;
    end
  end

  assign busy = (state_reg == ST_SHIFT);
  assign ovf  = ovf_reg;

  // --------------------------------------------------------------------------
  // Scan timing
  // --------------------------------------------------------------------------
  logic [PRE_W-1:0] pre_reg;
  logic             tick;
  logic [SEL_W-1:0] sel_reg;

  assign tick = (pre_reg == PRE_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_reg <= '0;
      sel_reg <= '0;
    end else begin
      if (tick) begin
        pre_reg <= '0;
        sel_reg <= (sel_reg == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel_reg + 1'b1;
      end else begin
        pre_reg <= pre_reg + 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Digit pattern generation
  // --------------------------------------------------------------------------
  logic [3:0]            disp_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] nib_zero;
  // zero_from[i] = digits i..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS-1:0] zero_from;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
      assign disp_nib[gi] = disp_reg[4*gi +: 4];
      assign nib_zero[gi] = (disp_reg[4*gi +: 4] == 4'd0);
    end
  endgenerate

  always_comb begin
    zero_from = '0;
    zero_from[NUM_DIGITS-1] = nib_zero[NUM_DIGITS-1];
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      zero_from[i] = nib_zero[i] & zero_from[i+1];
    end
  end

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef DISP_BLINK_EN
  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_W'(BLINK_TICKS - 1)) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end
`else
  // Blink inputs have no effect in this build.
  logic unused_blink;
  assign unused_blink = ^{blink_mask, BLINK_W'(BLINK_TICKS - 1)};
`endif

  logic [6:0] seg_pat;
  logic       dp_pat;

  always_comb begin
    seg_pat = hex_to_seg(disp_nib[sel_reg]);
    dp_pat  = ~dp_in[sel_reg];
    if (ovf_reg) begin
      seg_pat = SEG_DASH;
    end else if (blank_lz && (sel_reg != '0) && zero_from[sel_reg]) begin
      seg_pat = SEG_OFF;
    end
`ifdef DISP_BLINK_EN
    if (blink_phase_reg && blink_mask[sel_reg]) begin
      seg_pat = SEG_OFF;
      dp_pat  = 1'b1;
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Registered pin drivers; they only move on a scan tick.
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_reg;
  logic [6:0]            seg_reg;
  logic                  dp_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_reg  <= '1;
      seg_reg <= SEG_OFF;
      dp_reg  <= 1'b1;
    end else if (tick) begin
      an_reg  <= ~(NUM_DIGITS'(1) << sel_reg);
      seg_reg <= seg_pat;
      dp_reg  <= dp_pat;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule
